// File: rtl/intr_ctrl.sv
// Vectored interrupt controller: edge-detected sources, fixed priority, nested-return PC stack,
// software trigger and a small register file for enables, pending and status.
module intr_ctrl #(
  parameter int          NUM_SRC     = 4,
  parameter int          PC_W        = 8,
  parameter int          STACK_DEPTH = 2,
  parameter int unsigned VEC_BASE    = 19,
  parameter int unsigned VEC_STRIDE  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [15:0]        cfg_wdata,
  output logic [15:0]        cfg_rdata,
  output logic               int_req,
  output logic [PC_W-1:0]    int_vector,
  input  logic               int_ack,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               ret_req,
  output logic               ret_valid,
  output logic [PC_W-1:0]    pc_ret
);

  localparam logic [3:0] LVL_NONE  = 4'hF;
  localparam logic [3:0] DEPTH_MAX = 4'(STACK_DEPTH);
  localparam int         SP_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int         SLOTS     = 1 << SP_W;

  typedef enum logic {IDLE, REQ} state_t;

  state_t              state_q, state_d;
  logic [NUM_SRC-1:0]  irq_p0, irq_p1, irq_p2;
  logic [NUM_SRC-1:0]  pending, pend_d, enable, elig;
  logic                gie, err, err_d;
  logic [3:0]          active, active_d, depth, depth_d, depth_pop, depth_m1;
  logic [3:0]          win_idx, win_q, lvl_pop;
  logic                any_elig, en_win, stack_empty, push_en, pop_ok;
  logic [SP_W-1:0]     pop_idx, push_idx;
  logic [PC_W-1:0]     stk_pc  [SLOTS];
  logic [3:0]          stk_lvl [SLOTS];
  logic                unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  function automatic logic [PC_W-1:0] vec_of(input logic [3:0] idx);
    logic [31:0] v;
    v = VEC_BASE + 32'(idx) * VEC_STRIDE;
    return v[PC_W-1:0];
  endfunction

  // Priority selection over sources that may preempt the currently active level
  always_comb begin
    elig     = '0;
    any_elig = 1'b0;
    win_idx  = '0;
    en_win   = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      elig[i] = gie & enable[i] & pending[i] & (4'(i) < active) & (depth < DEPTH_MAX);
      if (elig[i]) begin
        any_elig = 1'b1;
        win_idx  = 4'(i);
      end
      if (win_q == 4'(i)) en_win = enable[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (any_elig) state_d = REQ;
      REQ: begin
        if (int_ack)              state_d = IDLE;
        else if (!gie || !en_win) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Return pop resolves before the acknowledge push when both land together
  always_comb begin
    stack_empty = (depth == 4'd0);
    pop_ok      = ret_req & ~stack_empty;
    depth_m1    = depth - 4'd1;
    pop_idx     = depth_m1[SP_W-1:0];
    depth_pop   = pop_ok ? depth_m1 : depth;
    lvl_pop     = pop_ok ? stk_lvl[pop_idx] : active;
    push_en     = (state_q == REQ) & int_ack;
    push_idx    = depth_pop[SP_W-1:0];
    depth_d     = push_en ? depth_pop + 4'd1 : depth_pop;
    active_d    = push_en ? win_q : lvl_pop;

    err_d = err;
    if (cfg_we && cfg_addr == 2'd2) err_d = 1'b0;
    if (ret_req && stack_empty)     err_d = 1'b1;

    pend_d = pending;
    if (cfg_we && cfg_addr == 2'd1) pend_d = pend_d & ~cfg_wdata[NUM_SRC-1:0];
    if (push_en) begin
      for (int i = 0; i < NUM_SRC; i++)
        if (win_q == 4'(i)) pend_d[i] = 1'b0;
    end
    pend_d = pend_d | (irq_p1 & ~irq_p2);
    if (cfg_we && cfg_addr == 2'd3) pend_d = pend_d | cfg_wdata[NUM_SRC-1:0];
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0: begin
        cfg_rdata[15]          = gie;
        cfg_rdata[NUM_SRC-1:0] = enable;
      end
      2'd1: cfg_rdata[NUM_SRC-1:0] = pending;
      2'd2: cfg_rdata[7:0] = {err, depth[2:0], active};
      default: cfg_rdata = '0;
    endcase
  end

  assign int_req = (state_q == REQ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_p0     <= '0;
      irq_p1     <= '0;
      irq_p2     <= '0;
      pending    <= '0;
      enable     <= '0;
      gie        <= 1'b0;
      err        <= 1'b0;
      state_q    <= IDLE;
      win_q      <= '0;
      int_vector <= '0;
      ret_valid  <= 1'b0;
      pc_ret     <= '0;
      depth      <= '0;
      active     <= LVL_NONE;
      for (int i = 0; i < SLOTS; i++) begin
        stk_pc[i]  <= '0;
        stk_lvl[i] <= '0;
      end
    end else begin
      // Synchroniser stages p0/p1, edge reference p2
      irq_p0  <= irq_in;
      irq_p1  <= irq_p0;
      irq_p2  <= irq_p1;
      pending <= pend_d;
      err     <= err_d;
      state_q <= state_d;
      depth   <= depth_d;
      active  <= active_d;
      if (cfg_we && cfg_addr == 2'd0) begin
        gie    <= cfg_wdata[15];
        enable <= cfg_wdata[NUM_SRC-1:0];
      end
      if (state_q == IDLE && any_elig) begin
        win_q      <= win_idx;
        int_vector <= vec_of(win_idx);
      end
      ret_valid <= ret_req;
      if (ret_req) pc_ret <= stack_empty ? '0 : stk_pc[pop_idx];
      if (push_en) begin
        stk_pc[push_idx]  <= pc_in;
        stk_lvl[push_idx] <= lvl_pop;
      end
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: a two-level instance plus a one-level instance sharing stimulus.
module tb_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  irq_in = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic        int_ack = 1'b0;
  logic [7:0]  pc_in = '0;
  logic        ret_req = 1'b0;
  logic [15:0] cfg_rdata, cfg_rdata_s;
  logic        int_req, int_req_s, ret_valid, ret_valid_s;
  logic [7:0]  int_vector, int_vector_s, pc_ret, pc_ret_s;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_vec_q[$];
  logic [7:0] exp_ret_q[$];

  always #5 clk = ~clk;

  intr_ctrl #(.NUM_SRC(4), .PC_W(8), .STACK_DEPTH(2), .VEC_BASE(19), .VEC_STRIDE(16)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .int_req(int_req), .int_vector(int_vector),
    .int_ack(int_ack), .pc_in(pc_in), .ret_req(ret_req), .ret_valid(ret_valid), .pc_ret(pc_ret));

  intr_ctrl #(.NUM_SRC(4), .PC_W(8), .STACK_DEPTH(1), .VEC_BASE(19), .VEC_STRIDE(16)) dut_s (
    .clk(clk), .rst(rst), .irq_in(irq_in), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata_s), .int_req(int_req_s), .int_vector(int_vector_s),
    .int_ack(int_ack), .pc_in(pc_in), .ret_req(ret_req), .ret_valid(ret_valid_s), .pc_ret(pc_ret_s));

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; irq_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    int_ack = 1'b0; pc_in = '0; ret_req = 1'b0;
    exp_vec_q.delete();
    exp_ret_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0; cfg_wdata = '0;
  endtask

  task automatic cfg_read(input logic [1:0] a, input bit single, output logic [15:0] d);
    cfg_addr = a;
    #1;
    d = single ? cfg_rdata_s : cfg_rdata;
  endtask

  task automatic raise(input logic [3:0] mask);
    irq_in = mask;
    @(negedge clk);
    irq_in = '0;
  endtask

  task automatic wait_req(input bit single, input int budget, output int cycles);
    cycles = 0;
    while (!(single ? int_req_s : int_req) && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic ack(input logic [7:0] pc);
    int_ack = 1'b1; pc_in = pc;
    @(negedge clk);
    int_ack = 1'b0; pc_in = '0;
  endtask

  task automatic ret(input bit single, output logic v, output logic [7:0] pc);
    ret_req = 1'b1;
    @(negedge clk);
    v  = single ? ret_valid_s : ret_valid;
    pc = single ? pc_ret_s : pc_ret;
    ret_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] rd;
    do_reset();
    n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL reset_int_req: got %b want 0", int_req); end
    n_checks++; if (int_vector !== 8'd0) begin n_fail++; $display("FAIL reset_vector: got %0d want 0", int_vector); end
    n_checks++; if (ret_valid !== 1'b0 || pc_ret !== 8'd0) begin n_fail++; $display("FAIL reset_ret: got %b/%h want 0/00", ret_valid, pc_ret); end
    for (int a = 0; a < 4; a++) begin
      cfg_read(2'(a), 1'b0, rd);
      n_checks++;
      if (rd !== ((a == 2) ? 16'h000F : 16'h0000)) begin
        n_fail++; $display("FAIL reset_reg%0d: got %h want %h", a, rd, (a == 2) ? 16'h000F : 16'h0000);
      end
    end
  endtask

  task automatic test_basic();
    int lat; logic [15:0] rd; logic v; logic [7:0] pc, exp;
    do_reset();
    cfg_write(2'd0, 16'h8003);
    exp_vec_q.push_back(8'd35);
    irq_in = 4'b0010; lat = 0;
    while (!int_req && lat < 10) begin @(negedge clk); lat++; irq_in = '0; end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d cycles want 4", lat); end
    exp = exp_vec_q.pop_front();
    n_checks++; if (int_vector !== exp) begin n_fail++; $display("FAIL basic_vector: got %0d want %0d", int_vector, exp); end
    cfg_read(2'd1, 1'b0, rd);
    n_checks++; if (rd !== 16'h0002) begin n_fail++; $display("FAIL basic_pending_set: got %h want 0002", rd); end
    ack(8'h05);
    n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_drop: got %b want 0", int_req); end
    cfg_read(2'd1, 1'b0, rd);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL basic_pending_clr: got %h want 0000", rd); end
    cfg_read(2'd2, 1'b0, rd);
    n_checks++; if (rd !== 16'h0011) begin n_fail++; $display("FAIL basic_status: got %h want 0011", rd); end
    exp_ret_q.push_back(8'h05);
    ret(1'b0, v, pc);
    exp = exp_ret_q.pop_front();
    n_checks++; if (v !== 1'b1 || pc !== exp) begin n_fail++; $display("FAIL basic_ret: got %b/%h want 1/%h", v, pc, exp); end
    cfg_read(2'd2, 1'b0, rd);
    n_checks++; if (rd !== 16'h000F) begin n_fail++; $display("FAIL basic_status_after_ret: got %h want 000F", rd); end
  endtask

  task automatic test_same_cycle();
    int cyc; bit quiet; logic v; logic [7:0] pc, exp;
    do_reset();
    cfg_write(2'd0, 16'h8003);
    exp_vec_q.push_back(8'd19);
    exp_vec_q.push_back(8'd35);
    raise(4'b0011);
    wait_req(1'b0, 8, cyc);
    exp = exp_vec_q.pop_front();
    n_checks++; if (int_req !== 1'b1 || int_vector !== exp) begin n_fail++; $display("FAIL same_first: got req=%b vec=%0d want 1/%0d", int_req, int_vector, exp); end
    exp_ret_q.push_back(8'h10);
    ack(8'h10);
    quiet = 1'b1;
    repeat (4) begin @(negedge clk); if (int_req) quiet = 1'b0; end
    n_checks++; if (!quiet) begin n_fail++; $display("FAIL same_no_preempt: got req=1 want 0 while src0 active"); end
    ret(1'b0, v, pc);
    exp = exp_ret_q.pop_front();
    n_checks++; if (v !== 1'b1 || pc !== exp) begin n_fail++; $display("FAIL same_ret: got %b/%h want 1/%h", v, pc, exp); end
    wait_req(1'b0, 6, cyc);
    exp = exp_vec_q.pop_front();
    n_checks++; if (int_req !== 1'b1 || int_vector !== exp) begin n_fail++; $display("FAIL same_second: got req=%b vec=%0d want 1/%0d", int_req, int_vector, exp); end
    ack(8'h20);
    exp_ret_q.push_back(8'h20);
    ret(1'b0, v, pc);
    exp = exp_ret_q.pop_front();
    n_checks++; if (v !== 1'b1 || pc !== exp) begin n_fail++; $display("FAIL same_ret2: got %b/%h want 1/%h", v, pc, exp); end
  endtask

  task automatic test_nested();
    int cyc; bit quiet; logic [15:0] rd; logic v; logic [7:0] pc, exp;
    do_reset();
    cfg_write(2'd0, 16'h8007);
    exp_vec_q.push_back(8'd35);
    raise(4'b0010);
    wait_req(1'b0, 8, cyc);
    exp = exp_vec_q.pop_front();
    n_checks++; if (int_vector !== exp || int_req !== 1'b1) begin n_fail++; $display("FAIL nest_outer: got req=%b vec=%0d want 1/%0d", int_req, int_vector, exp); end
    ack(8'h05);
    exp_vec_q.push_back(8'd19);
    raise(4'b0101);
    wait_req(1'b0, 8, cyc);
    exp = exp_vec_q.pop_front();
    n_checks++; if (int_vector !== exp || int_req !== 1'b1) begin n_fail++; $display("FAIL nest_inner: got req=%b vec=%0d want 1/%0d", int_req, int_vector, exp); end
    ack(8'h33);
    cfg_read(2'd2, 1'b0, rd);
    n_checks++; if (rd !== 16'h0020) begin n_fail++; $display("FAIL nest_status: got %h want 0020", rd); end
    cfg_read(2'd1, 1'b0, rd);
    n_checks++; if (rd !== 16'h0004) begin n_fail++; $display("FAIL nest_pending: got %h want 0004", rd); end
    exp_ret_q.push_back(8'h33);
    exp_ret_q.push_back(8'h05);
    ret(1'b0, v, pc);
    exp = exp_ret_q.pop_front();
    n_checks++; if (v !== 1'b1 || pc !== exp) begin n_fail++; $display("FAIL nest_ret_inner: got %b/%h want 1/%h", v, pc, exp); end
    quiet = 1'b1;
    repeat (4) begin @(negedge clk); if (int_req) quiet = 1'b0; end
    n_checks++; if (!quiet) begin n_fail++; $display("FAIL nest_low_blocked: got req=1 want 0 for src2 under src1"); end
    ret(1'b0, v, pc);
    exp = exp_ret_q.pop_front();
    n_checks++; if (v !== 1'b1 || pc !== exp) begin n_fail++; $display("FAIL nest_ret_outer: got %b/%h want 1/%h", v, pc, exp); end
    exp_vec_q.push_back(8'd51);
    wait_req(1'b0, 6, cyc);
    exp = exp_vec_q.pop_front();
    n_checks++; if (int_vector !== exp || int_req !== 1'b1) begin n_fail++; $display("FAIL nest_src2: got req=%b vec=%0d want 1/%0d", int_req, int_vector, exp); end
    ack(8'h40);
    ret(1'b0, v, pc);
  endtask

  task automatic test_depth1();
    int cyc; bit quiet; logic [15:0] rd; logic v; logic [7:0] pc, exp;
    do_reset();
    cfg_write(2'd0, 16'h8003);
    exp_vec_q.push_back(8'd35);
    raise(4'b0010);
    wait_req(1'b1, 8, cyc);
    exp = exp_vec_q.pop_front();
    n_checks++; if (int_vector_s !== exp || int_req_s !== 1'b1) begin n_fail++; $display("FAIL d1_first: got req=%b vec=%0d want 1/%0d", int_req_s, int_vector_s, exp); end
    ack(8'h05);
    raise(4'b0001);
    quiet = 1'b1;
    repeat (8) begin @(negedge clk); if (int_req_s) quiet = 1'b0; end
    n_checks++; if (!quiet) begin n_fail++; $display("FAIL d1_full_blocks: got req=1 want 0 with stack full"); end
    cfg_read(2'd1, 1'b1, rd);
    n_checks++; if (rd !== 16'h0001) begin n_fail++; $display("FAIL d1_pending: got %h want 0001", rd); end
    cfg_read(2'd2, 1'b1, rd);
    n_checks++; if (rd !== 16'h0011) begin n_fail++; $display("FAIL d1_status: got %h want 0011", rd); end
    exp_ret_q.push_back(8'h05);
    exp_vec_q.push_back(8'd19);
    ret(1'b1, v, pc);
    exp = exp_ret_q.pop_front();
    n_checks++; if (v !== 1'b1 || pc !== exp) begin n_fail++; $display("FAIL d1_ret: got %b/%h want 1/%h", v, pc, exp); end
    wait_req(1'b1, 6, cyc);
    exp = exp_vec_q.pop_front();
    n_checks++; if (int_vector_s !== exp || int_req_s !== 1'b1) begin n_fail++; $display("FAIL d1_after_ret: got req=%b vec=%0d want 1/%0d", int_req_s, int_vector_s, exp); end
  endtask

  task automatic test_underflow();
    logic [15:0] rd; logic v; logic [7:0] pc, exp;
    do_reset();
    exp_ret_q.push_back(8'h00);
    ret(1'b0, v, pc);
    exp = exp_ret_q.pop_front();
    n_checks++; if (v !== 1'b1 || pc !== exp) begin n_fail++; $display("FAIL uf_ret: got %b/%h want 1/%h", v, pc, exp); end
    cfg_read(2'd2, 1'b0, rd);
    n_checks++; if (rd !== 16'h008F) begin n_fail++; $display("FAIL uf_status: got %h want 008F", rd); end
    @(negedge clk);
    n_checks++; if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL uf_pulse: got %b want 0", ret_valid); end
    cfg_write(2'd2, 16'h0000);
    cfg_read(2'd2, 1'b0, rd);
    n_checks++; if (rd !== 16'h000F) begin n_fail++; $display("FAIL uf_clear: got %h want 000F", rd); end
  endtask

  task automatic test_w1c();
    logic [15:0] rd;
    do_reset();
    raise(4'b0011);
    repeat (3) @(negedge clk);
    cfg_read(2'd1, 1'b0, rd);
    n_checks++; if (rd !== 16'h0003) begin n_fail++; $display("FAIL w1c_capture: got %h want 0003", rd); end
    cfg_write(2'd1, 16'h0001);
    cfg_read(2'd1, 1'b0, rd);
    n_checks++; if (rd !== 16'h0002) begin n_fail++; $display("FAIL w1c_clear: got %h want 0002", rd); end
    @(negedge clk);
    irq_in = 4'b0100;
    @(negedge clk);
    irq_in = '0;
    @(negedge clk);
    cfg_write(2'd1, 16'h0004);
    cfg_read(2'd1, 1'b0, rd);
    n_checks++; if (rd !== 16'h0006) begin n_fail++; $display("FAIL w1c_set_wins: got %h want 0006", rd); end
    cfg_write(2'd1, 16'hFFFF);
    cfg_read(2'd1, 1'b0, rd);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL w1c_all: got %h want 0000", rd); end
  endtask

  task automatic test_swset_gie();
    int cyc; logic [15:0] rd; logic [7:0] exp;
    do_reset();
    cfg_write(2'd0, 16'h8004);
    exp_vec_q.push_back(8'd51);
    cfg_write(2'd3, 16'h0004);
    cfg_read(2'd3, 1'b0, rd);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL sw_readback: got %h want 0000", rd); end
    wait_req(1'b0, 6, cyc);
    exp = exp_vec_q.pop_front();
    n_checks++; if (int_vector !== exp || int_req !== 1'b1) begin n_fail++; $display("FAIL sw_req: got req=%b vec=%0d want 1/%0d", int_req, int_vector, exp); end
    cfg_write(2'd0, 16'h0004);
    cyc = 0;
    while (int_req && cyc < 4) begin @(negedge clk); cyc++; end
    n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL sw_gie_drop: got req=%b want 0", int_req); end
    cfg_read(2'd1, 1'b0, rd);
    n_checks++; if (rd !== 16'h0004) begin n_fail++; $display("FAIL sw_pending_kept: got %h want 0004", rd); end
    exp_vec_q.push_back(8'd51);
    cfg_write(2'd0, 16'h8004);
    wait_req(1'b0, 6, cyc);
    exp = exp_vec_q.pop_front();
    n_checks++; if (int_vector !== exp || int_req !== 1'b1) begin n_fail++; $display("FAIL sw_rereq: got req=%b vec=%0d want 1/%0d", int_req, int_vector, exp); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (int_req !== 1'b0 || int_vector !== 8'd0) begin n_fail++; $display("FAIL async_reset: got req=%b vec=%0d want 0/0", int_req, int_vector); end
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_same_cycle();
    test_nested();
    test_depth1();
    test_underflow();
    test_w1c();
    test_swset_gie();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
